// File: rtl/hazard_pkg.sv
// Shared types and select encodings for the pipeline hazard unit and its
// multi-cycle op tracker.
package hazard_pkg;

  // Shadow copy of one post-decode pipeline stage.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_wr;
    logic       mem_read;
  } stage_rec_t;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } mc_state_e;

  localparam int unsigned DEF_NUM_STAGES = 3;

  // Forward-select encodings: 0 reads the regfile, k reads stage k, and
  // the slot just past the last stage carries the multi-cycle result.
  localparam int unsigned FWD_RF = 0;
  localparam int unsigned FWD_MC = DEF_NUM_STAGES + 1;

  function automatic int unsigned fwd_mc_sel(input int unsigned num_stages);
    return num_stages + 1;
  endfunction

  function automatic logic src_hit(input logic [4:0] rs, input stage_rec_t s);
    return s.valid && s.reg_wr && (s.rd != 5'd0) && (s.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_mc_track.sv
// Tracks the single in-flight multi-cycle op (mul/div): its destination
// register and the cycles left before its result writes back.
//   state   | meaning
//   MC_IDLE | no multi-cycle op in flight
//   MC_BUSY | op executing, cnt counts down the remaining latency
//   MC_DONE | result writes back this cycle (mc_wb)
module hazard_mc_track
  import hazard_pkg::*;
#(
  parameter int MC_LAT_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [MC_LAT_W-1:0] lat_i,
  input  logic [4:0]          rd_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [4:0]          mc_rd_o
);

  mc_state_e           state_q, state_d;
  logic [MC_LAT_W-1:0] cnt_q, cnt_d;
  logic [4:0]          mc_rd_q, mc_rd_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= MC_IDLE;
      cnt_q   <= '0;
      mc_rd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mc_rd_q <= mc_rd_d;
    end
  end

  // DONE lands exactly lat cycles after the issue cycle; lat = 1 skips BUSY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mc_rd_d = mc_rd_q;
    unique case (state_q)
      MC_IDLE, MC_DONE: begin
        state_d = MC_IDLE;
        if (start_i) begin
          mc_rd_d = rd_i;
          cnt_d   = lat_i - 1'b1;
          state_d = (lat_i > MC_LAT_W'(1)) ? MC_BUSY : MC_DONE;
        end
      end
      MC_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) state_d = MC_DONE;
      end
      default: state_d = MC_IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state_q == MC_BUSY);
    done_o  = (state_q == MC_DONE);
    mc_rd_o = mc_rd_q;
  end

endmodule

// File: rtl/hazard_unit_ms.sv
// In-order pipeline hazard unit: stage shadowing, forwarding selects,
// load-use / multi-cycle stalls and redirect flush. Forwarding is built only
// when HAZARD_FWD_EN is defined; otherwise dependences stall until resolved.
module hazard_unit_ms
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES       = DEF_NUM_STAGES,
  parameter int LOAD_AVAIL_STAGE = 2,
  parameter int MC_LAT_W         = 4,
  parameter int FLUSH_CYCLES     = 1,
  localparam int FW              = $clog2(NUM_STAGES + 2)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [4:0]          id_rs1,
  input  logic [4:0]          id_rs2,
  input  logic                id_rs1_used,
  input  logic                id_rs2_used,
  input  logic [4:0]          id_rd,
  input  logic                id_reg_wr,
  input  logic                id_mem_read,
  input  logic                id_mc,
  input  logic [MC_LAT_W-1:0] id_mc_lat,
  input  logic                pc_sel,
  output logic [FW-1:0]       fwd_a,
  output logic [FW-1:0]       fwd_b,
  output logic                stall,
  output logic                flush,
  output logic                mc_wb
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  stage_rec_t          stage_q [1:NUM_STAGES];
  stage_rec_t          stage_d [1:NUM_STAGES];
  logic [FC_W-1:0]     fcnt_q, fcnt_d;
  logic [NUM_STAGES:1] hit_a, hit_b, early;
  logic                ld_a, ld_b, mc_a, mc_b;
  logic                mc_busy, mc_done;
  logic [4:0]          mc_rd;
  logic                stall_dep, stall_mc, stall_int, flush_int, issue;
  logic [FW-1:0]       sel_a, sel_b;

  hazard_mc_track #(.MC_LAT_W(MC_LAT_W)) u_mc_track (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (issue & id_mc),
    .lat_i   (id_mc_lat),
    .rd_i    (id_reg_wr ? id_rd : 5'd0),
    .busy_o  (mc_busy),
    .done_o  (mc_done),
    .mc_rd_o (mc_rd)
  );

  always_comb begin
    for (int k = 1; k <= NUM_STAGES; k++) begin
      hit_a[k] = id_valid && id_rs1_used && src_hit(id_rs1, stage_q[k]);
      hit_b[k] = id_valid && id_rs2_used && src_hit(id_rs2, stage_q[k]);
      early[k] = stage_q[k].mem_read && (k < LOAD_AVAIL_STAGE);
    end
    mc_a = id_valid && id_rs1_used && mc_done && (mc_rd != 5'd0) && (id_rs1 == mc_rd);
    mc_b = id_valid && id_rs2_used && mc_done && (mc_rd != 5'd0) && (id_rs2 == mc_rd);
  end

  // Walk oldest to youngest so the youngest hit decides.
  always_comb begin
    ld_a = 1'b0;
    ld_b = 1'b0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (hit_a[k]) ld_a = early[k];
      if (hit_b[k]) ld_b = early[k];
    end
  end

`ifdef HAZARD_FWD_EN
  always_comb begin
    sel_a = mc_a ? FW'(fwd_mc_sel(NUM_STAGES)) : FW'(FWD_RF);
    sel_b = mc_b ? FW'(fwd_mc_sel(NUM_STAGES)) : FW'(FWD_RF);
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (hit_a[k]) sel_a = FW'(k);
      if (hit_b[k]) sel_b = FW'(k);
    end
    if (ld_a) sel_a = FW'(FWD_RF);
    if (ld_b) sel_b = FW'(FWD_RF);
  end
  assign stall_dep = ld_a | ld_b;
`else
  assign sel_a     = FW'(FWD_RF);
  assign sel_b     = FW'(FWD_RF);
  assign stall_dep = ld_a | ld_b | (|hit_a) | (|hit_b) | mc_a | mc_b;
`endif

  // RAW and WAW against the pending result, plus one tracker only.
  assign stall_mc = id_valid && mc_busy &&
                    (id_mc || ((mc_rd != 5'd0) &&
                     ((id_rs1_used && (id_rs1 == mc_rd)) ||
                      (id_rs2_used && (id_rs2 == mc_rd)) ||
                      (id_reg_wr   && (id_rd  == mc_rd)))));

  assign flush_int = pc_sel | (fcnt_q != '0);
  assign stall_int = (stall_dep | stall_mc) & ~flush_int;
  assign issue     = id_valid & ~stall_int & ~flush_int;

  always_comb begin
    fcnt_d = fcnt_q;
    if (pc_sel)              fcnt_d = FC_W'(FLUSH_CYCLES - 1);
    else if (fcnt_q != '0)   fcnt_d = fcnt_q - 1'b1;
  end

  always_comb begin
    stage_d[1] = '0;
    if (issue && !id_mc)
      stage_d[1] = '{valid: 1'b1, rd: id_rd, reg_wr: id_reg_wr, mem_read: id_mem_read};
    for (int k = 2; k <= NUM_STAGES; k++) stage_d[k] = stage_q[k-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q <= '0;
      for (int k = 1; k <= NUM_STAGES; k++) stage_q[k] <= '0;
    end else begin
      fcnt_q <= fcnt_d;
      for (int k = 1; k <= NUM_STAGES; k++) stage_q[k] <= stage_d[k];
    end
  end

  assign stall = ~rst & stall_int;
  assign flush = ~rst & flush_int;
  assign mc_wb = ~rst & mc_done;
  assign fwd_a = rst ? FW'(FWD_RF) : sel_a;
  assign fwd_b = rst ? FW'(FWD_RF) : sel_b;

endmodule

// File: tb/tb_hazard_unit_ms.sv
// Directed bench for hazard_unit_ms with FLUSH_CYCLES = 2; expectations
// follow the forwarding build when HAZARD_FWD_EN is defined.
module tb_hazard_unit_ms;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs1_used, id_rs2_used, id_reg_wr, id_mem_read, id_mc, pc_sel;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [3:0] id_mc_lat;
  logic [2:0] fwd_a, fwd_b;
  logic       stall, flush, mc_wb;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_unit_ms #(
    .NUM_STAGES       (3),
    .LOAD_AVAIL_STAGE (2),
    .MC_LAT_W         (4),
    .FLUSH_CYCLES     (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_reg_wr   (id_reg_wr),
    .id_mem_read (id_mem_read),
    .id_mc       (id_mc),
    .id_mc_lat   (id_mc_lat),
    .pc_sel      (pc_sel),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall       (stall),
    .flush       (flush),
    .mc_wb       (mc_wb)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                     input logic wr, input logic mr, input logic mc, input logic [3:0] lat);
    id_valid    = v;
    id_rs1      = rs1;
    id_rs1_used = u1;
    id_rs2      = rs2;
    id_rs2_used = u2;
    id_rd       = rd;
    id_reg_wr   = wr;
    id_mem_read = mr;
    id_mc       = mc;
    id_mc_lat   = lat;
  endtask

  task automatic nop();
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd1);
  endtask

  task automatic drain();
    nop();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    // reset with busy-looking inputs: every output must stay quiet
    rst    = 1'b1;
    pc_sel = 1'b1;
    drv(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 4'd4);
    #2;
    chk("rst_stall", 8'(stall), 8'd0);
    chk("rst_flush", 8'(flush), 8'd0);
    chk("rst_mc_wb", 8'(mc_wb), 8'd0);
    chk("rst_fwd_a", 8'(fwd_a), 8'd0);
    chk("rst_fwd_b", 8'(fwd_b), 8'd0);
    @(negedge clk);
    rst    = 1'b0;
    pc_sel = 1'b0;
    nop();
    #1;
    chk("post_rst_flush", 8'(flush), 8'd0);
    @(negedge clk);

    // 1: ALU x5 -> reader of x5
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 4'd1);
    #1; chk("s1_prod_stall", 8'(stall), 8'd0);
    @(negedge clk);
    drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 4'd1);
`ifdef HAZARD_FWD_EN
    #1; chk("s1_fwd_ex", 8'(fwd_a), 8'd1); chk("s1_stall", 8'(stall), 8'd0);
    @(negedge clk);
    drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd1);
    #1; chk("s1_fwd_mem", 8'(fwd_a), 8'd2); chk("s1_stall2", 8'(stall), 8'd0);
    @(negedge clk);
`else
    for (int i = 0; i < 3; i++) begin
      #1; chk("s1_stall_hold", 8'(stall), 8'd1); chk("s1_fwd_tied", 8'(fwd_a), 8'd0);
      @(negedge clk);
    end
    #1; chk("s1_stall_release", 8'(stall), 8'd0);
    @(negedge clk);
`endif
    drain();

    // 2: load x7 -> reader rs2 = x7
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 4'd1);
    #1; chk("s2_load_stall", 8'(stall), 8'd0);
    @(negedge clk);
    drv(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 4'd1);
`ifdef HAZARD_FWD_EN
    #1; chk("s2_luse_stall", 8'(stall), 8'd1); chk("s2_luse_fwd", 8'(fwd_b), 8'd0);
    @(negedge clk);
    #1; chk("s2_release", 8'(stall), 8'd0); chk("s2_fwd_mem", 8'(fwd_b), 8'd2);
    @(negedge clk);
`else
    for (int i = 0; i < 3; i++) begin
      #1; chk("s2_stall_hold", 8'(stall), 8'd1); chk("s2_fwd_tied", 8'(fwd_b), 8'd0);
      @(negedge clk);
    end
    #1; chk("s2_release", 8'(stall), 8'd0);
    @(negedge clk);
`endif
    drain();

    // 3: mul x9 lat 4 -> reader of x9
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 4'd4);
    #1; chk("s3_issue_stall", 8'(stall), 8'd0); chk("s3_issue_wb", 8'(mc_wb), 8'd0);
    @(negedge clk);
    drv(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 4'd1);
    for (int i = 0; i < 3; i++) begin
      #1; chk("s3_busy_stall", 8'(stall), 8'd1); chk("s3_busy_wb", 8'(mc_wb), 8'd0);
      @(negedge clk);
    end
    #1; chk("s3_done_wb", 8'(mc_wb), 8'd1);
`ifdef HAZARD_FWD_EN
    chk("s3_done_fwd", 8'(fwd_a), 8'd4); chk("s3_done_stall", 8'(stall), 8'd0);
    @(negedge clk);
    nop();
    #1; chk("s3_after_wb", 8'(mc_wb), 8'd0);
`else
    chk("s3_done_fwd", 8'(fwd_a), 8'd0); chk("s3_done_stall", 8'(stall), 8'd1);
    @(negedge clk);
    #1; chk("s3_after_wb", 8'(mc_wb), 8'd0); chk("s3_after_stall", 8'(stall), 8'd0);
`endif
    @(negedge clk);
    drain();

    // 4: redirect during a load-use stall; the killed op writes x12
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 4'd1);
    #1; chk("s4_load_stall", 8'(stall), 8'd0);
    @(negedge clk);
    drv(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 4'd1);
    pc_sel = 1'b1;
    #1; chk("s4_flush_c1", 8'(flush), 8'd1); chk("s4_stall_c1", 8'(stall), 8'd0);
    @(negedge clk);
    pc_sel = 1'b0;
    #1; chk("s4_flush_c2", 8'(flush), 8'd1); chk("s4_stall_c2", 8'(stall), 8'd0);
    @(negedge clk);
    drv(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd1);
    #1; chk("s4_flush_c3", 8'(flush), 8'd0);
    chk("s4_bubble_stall", 8'(stall), 8'd0);
    chk("s4_bubble_fwd", 8'(fwd_a), 8'd0);
    @(negedge clk);
    drain();

    // 5: x0 producer and consumer
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 4'd1);
    #1; chk("s5_prod_stall", 8'(stall), 8'd0);
    @(negedge clk);
    drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 4'd1);
    #1; chk("s5_stall", 8'(stall), 8'd0);
    chk("s5_fwd_a", 8'(fwd_a), 8'd0);
    chk("s5_fwd_b", 8'(fwd_b), 8'd0);
    @(negedge clk);
    drain();

    // 6: reset while the multi-cycle op is busy
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 4'd4);
    @(negedge clk);
    drv(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 4'd1);
    #1; chk("s6_busy_stall", 8'(stall), 8'd1);
    #1;
    rst    = 1'b1;
    pc_sel = 1'b1;
    #1;
    chk("s6_rst_stall", 8'(stall), 8'd0);
    chk("s6_rst_flush", 8'(flush), 8'd0);
    chk("s6_rst_wb", 8'(mc_wb), 8'd0);
    chk("s6_rst_fwd_a", 8'(fwd_a), 8'd0);
    chk("s6_rst_fwd_b", 8'(fwd_b), 8'd0);
    @(negedge clk);
    rst    = 1'b0;
    pc_sel = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1; chk("s6_no_wb", 8'(mc_wb), 8'd0); chk("s6_no_stall", 8'(stall), 8'd0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit_ms.md
HAZARD_UNIT_MS -- requirements
Module: hazard_unit_ms

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3, number of post-decode stages tracked (stage 1 = EX, stage NUM_STAGES = WB).
REQ-002 SHALL have parameter LOAD_AVAIL_STAGE, default 2, first stage whose load data can be forwarded.
REQ-003 SHALL have parameter MC_LAT_W, default 4, width of the multi-cycle latency field.
REQ-004 SHALL have parameter FLUSH_CYCLES, default 1, cycles that flush is held per redirect.
REQ-005 Ports, in order:
- clk in 1: the single clock.
- rst in 1: asynchronous, active-high reset.
- id_valid in 1: decode holds an instruction.
- id_rs1, id_rs2 in 5: source register addresses.
- id_rs1_used, id_rs2_used in 1: source is read.
- id_rd in 5: destination register.
- id_reg_wr in 1: instruction writes rd.
- id_mem_read in 1: instruction is a load.
- id_mc in 1: multi-cycle op (mul/div).
- id_mc_lat in MC_LAT_W: multi-cycle latency, 1 or more.
- pc_sel in 1: taken redirect from EX.
- fwd_a, fwd_b out FW = $clog2(NUM_STAGES+2): 0 = regfile, k = stage k, NUM_STAGES+1 = MC result.
- stall out 1: hold PC/IF/ID.
- flush out 1: kill IF/ID.
- mc_wb out 1: MC result writes back this cycle.

Function
REQ-006 SHALL hold a shadow record per stage: valid, rd, reg_wr, mem_read.
REQ-007 issue SHALL equal id_valid & !stall & !flush.
- Each cycle stage1 <= issue ? ID record : bubble.
- Stage k+1 <= stage k for every k, regardless of stall.
REQ-008 A stage hit for a source SHALL require that source used, rs == rd, rd != 0, and reg_wr & valid in the stage.
REQ-009 Forwarding selects SHALL be combinational, with the lowest-numbered (youngest) hit taking priority; no hit gives 0.
REQ-010 A load hit at stage k < LOAD_AVAIL_STAGE SHALL assert stall, with fwd for that source = 0.
REQ-011 The MC FSM SHALL have three states:
- IDLE -> BUSY on issue & id_mc; load cnt = id_mc_lat - 1 and latch mc_rd.
- BUSY: decrement cnt; at cnt == 0 go to DONE.
- DONE: mc_wb = 1 for one cycle, then IDLE.
- An MC op SHALL NOT enter the shadow stages.
REQ-012 In BUSY, stall SHALL assert when ID reads mc_rd (RAW), writes mc_rd (WAW), or is id_mc (structural).
REQ-013 In DONE, a source matching mc_rd SHALL select NUM_STAGES+1 unless a younger stage hit wins.
REQ-014 flush SHALL assert combinationally when pc_sel = 1 and remain high for FLUSH_CYCLES-1 further cycles via a down-counter.
- A new pc_sel during the hold reloads the counter.
REQ-015 flush SHALL force stall = 0 in the same cycle.
- Older in-flight MC ops and stages 2..NUM_STAGES SHALL be unaffected.
REQ-016 rd = x0 SHALL never cause a stall or a forward.

Reset
REQ-017 rst SHALL asynchronously clear all shadow valids, cnt, and the flush counter, and set FSM = IDLE.
- Outputs during reset: stall = 0, flush = 0, mc_wb = 0, fwd_a = fwd_b = 0.
REQ-018 Reset during BUSY SHALL abandon the op with no mc_wb.

Configuration
REQ-019 Macro HAZARD_FWD_EN:
- Defined: forwarding SHALL operate per REQ-009 to REQ-013.
- Undefined: fwd_a and fwd_b SHALL be tied to 0.
- Undefined: any stage hit or DONE match SHALL stall until the producer leaves WB, or until mc_wb has completed.

Structure
REQ-020 Package hazard_pkg SHALL hold:
- the stage-record typedef;
- the MC FSM state enum;
- FW-select constants FWD_RF and FWD_MC.
REQ-021 The MC tracker (FSM, cnt, mc_rd) SHALL be sub-module hazard_mc_track, instantiated once.

Verification
REQ-022 The bench SHALL cover these directed scenarios (each: stimulus -> required response):
1. ALU writes x5, next instruction reads rs1 = x5 -> fwd_a = 1 and stall = 0; one instruction later -> fwd_a = 2.
2. Load writes x7, next instruction reads rs2 = x7 -> stall = 1 for exactly 1 cycle, then fwd_b = 2.
3. id_mc with lat = 4 writing x9, followed by a consumer of x9:
   - stall high for 3 cycles;
   - DONE cycle: mc_wb = 1 and fwd = NUM_STAGES+1 (4 with defaults).
4. pc_sel pulse with FLUSH_CYCLES = 2 during a load-use stall -> flush high 2 cycles, stall 0, stage1 bubble.
5. Producer and consumer both use rd = x0 -> no stall, fwd = 0.
6. rst asserted mid-BUSY:
   - outputs immediately 0;
   - after release, no mc_wb;
   - with HAZARD_FWD_EN undefined, scenario 1 stalls 3 cycles instead.
